execute_stage: RTL

- Execute stage of the 5-stage RV32I pipeline.
- Consumes ForwardAE/ForwardBE from the forwarding hazard logic to select ALU operands from the register file, the WB result or the MEM-stage ALU result.
- Computes the ALU result, branch/jump target and taken decision.
- Registers the results into the EX/MEM pipeline register, which drives the memory stage and the RdM/RegWriteM inputs of the hazard logic.

---
 rtl/rv_pkg.sv | 48 ++++
 rtl/alu.sv | 32 +++
 rtl/execute_stage.sv | 123 ++++++++++++
 3 files changed

// File: rtl/rv_pkg.sv
// rtl/rv_pkg.sv - shared RV32I execute-stage types and constants
package rv_pkg;

  localparam int RV_XLEN = 32;
  localparam int RV_REGW = 5;

  typedef enum logic [2:0] {
    ALU_ADD = 3'b000,
    ALU_SUB = 3'b001,
    ALU_AND = 3'b010,
    ALU_OR  = 3'b011,
    ALU_XOR = 3'b100,
    ALU_SLT = 3'b101,
    ALU_SLL = 3'b110,
    ALU_SRL = 3'b111
  } alu_op_e;

  // 2'b11 is reserved and falls back to the register-file value
  typedef enum logic [1:0] {
    FWD_RF  = 2'b00,
    FWD_WB  = 2'b01,
    FWD_MEM = 2'b10
  } fwd_sel_e;

  typedef enum logic [1:0] {
    RES_ALU = 2'b00,
    RES_MEM = 2'b01,
    RES_PC4 = 2'b10
  } result_src_e;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  typedef struct packed {
    logic                 reg_write;
    logic                 mem_write;
    result_src_e          result_src;
    logic [RV_XLEN-1:0]   alu_result;
    logic [RV_XLEN-1:0]   write_data;
    logic [RV_XLEN-1:0]   pc_plus4;
    logic [RV_REGW-1:0]   rd;
  } ex_mem_t;

endpackage

// File: rtl/alu.sv
// rtl/alu.sv - combinational RV32I integer ALU
module alu
  import rv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  alu_op_e         op,
  output logic [XLEN-1:0] result
);

  logic w_lt;

  assign w_lt = $signed(a) < $signed(b);

  always_comb begin
    result = '0;
    case (op)
      ALU_ADD: result = a + b;
      ALU_SUB: result = a - b;
      ALU_AND: result = a & b;
      ALU_OR:  result = a | b;
      ALU_XOR: result = a ^ b;
      ALU_SLT: result = {{(XLEN-1){1'b0}}, w_lt};
      ALU_SLL: result = a << b[4:0];
      ALU_SRL: result = a >> b[4:0];
      default: result = '0;
    endcase
  end

endmodule

// File: rtl/execute_stage.sv
// rtl/execute_stage.sv - RV32I execute stage with operand forwarding and EX/MEM register
module execute_stage
  import rv_pkg::*;
#(
  parameter int XLEN = RV_XLEN,
  parameter int REGW = RV_REGW
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            RegWriteE,
  input  logic [1:0]      ResultSrcE,
  input  logic            MemWriteE,
  input  logic            JumpE,
  input  logic            BranchE,
  input  logic            JalrE,
  input  logic            ALUSrcE,
  input  logic [2:0]      ALUControlE,
  input  logic [2:0]      Funct3E,
  input  logic [XLEN-1:0] RD1E,
  input  logic [XLEN-1:0] RD2E,
  input  logic [XLEN-1:0] ImmExtE,
  input  logic [XLEN-1:0] PCE,
  input  logic [XLEN-1:0] PCPlus4E,
  input  logic [REGW-1:0] RdE,
  input  logic [1:0]      ForwardAE,
  input  logic [1:0]      ForwardBE,
  input  logic [XLEN-1:0] ResultW,
  input  logic            StallM,
  input  logic            FlushM,
  output logic            PCSrcE,
  output logic [XLEN-1:0] PCTargetE,
  output logic            RegWriteM,
  output logic            MemWriteM,
  output logic [1:0]      ResultSrcM,
  output logic [XLEN-1:0] ALUResultM,
  output logic [XLEN-1:0] WriteDataM,
  output logic [XLEN-1:0] PCPlus4M,
  output logic [REGW-1:0] RdM
);

  ex_mem_t         r_exm;
  ex_mem_t         w_exm_next;
  logic [XLEN-1:0] w_src_a;
  logic [XLEN-1:0] w_fwd_b;
  logic [XLEN-1:0] w_src_b;
  logic [XLEN-1:0] w_alu_result;
  logic            w_cond;

  always_comb begin
    w_src_a = RD1E;
    case (ForwardAE)
      FWD_WB:  w_src_a = ResultW;
      FWD_MEM: w_src_a = r_exm.alu_result;
      default: w_src_a = RD1E;
    endcase
  end

  always_comb begin
    w_fwd_b = RD2E;
    case (ForwardBE)
      FWD_WB:  w_fwd_b = ResultW;
      FWD_MEM: w_fwd_b = r_exm.alu_result;
      default: w_fwd_b = RD2E;
    endcase
  end

  assign w_src_b = ALUSrcE ? ImmExtE : w_fwd_b;

  alu #(.XLEN(XLEN)) u_alu (
    .a      (w_src_a),
    .b      (w_src_b),
    .op     (alu_op_e'(ALUControlE)),
    .result (w_alu_result)
  );

  // Branches compare the forwarded registers, never the immediate
  always_comb begin
    w_cond = 1'b0;
    case (Funct3E)
      F3_BEQ:  w_cond = (w_src_a == w_fwd_b);
      F3_BNE:  w_cond = (w_src_a != w_fwd_b);
      F3_BLT:  w_cond = ($signed(w_src_a) < $signed(w_fwd_b));
      F3_BGE:  w_cond = ($signed(w_src_a) >= $signed(w_fwd_b));
      F3_BLTU: w_cond = (w_src_a < w_fwd_b);
      F3_BGEU: w_cond = (w_src_a >= w_fwd_b);
      default: w_cond = 1'b0;
    endcase
  end

  assign PCSrcE    = rst & (JumpE | (BranchE & w_cond));
  assign PCTargetE = JalrE ? {w_alu_result[XLEN-1:1], 1'b0} : (PCE + ImmExtE);

  always_comb begin
    w_exm_next            = '0;
    w_exm_next.reg_write  = RegWriteE;
    w_exm_next.mem_write  = MemWriteE;
    w_exm_next.result_src = result_src_e'(ResultSrcE);
    w_exm_next.alu_result = w_alu_result;
    w_exm_next.write_data = w_fwd_b;
    w_exm_next.pc_plus4   = PCPlus4E;
    w_exm_next.rd         = RdE;
  end

  // Flush wins over stall; the zeroed RdM keeps a bubble from matching any forward
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_exm <= '0;
    end else if (FlushM) begin
      r_exm <= '0;
    end else if (!StallM) begin
      r_exm <= w_exm_next;
    end
  end

  assign RegWriteM  = r_exm.reg_write;
  assign MemWriteM  = r_exm.mem_write;
  assign ResultSrcM = r_exm.result_src;
  assign ALUResultM = r_exm.alu_result;
  assign WriteDataM = r_exm.write_data;
  assign PCPlus4M   = r_exm.pc_plus4;
  assign RdM        = r_exm.rd;

endmodule
